// File: rtl/cnt_out_change_fifo.sv
// Change detector on the upstream 8-bit output bus. Each value change is time-stamped
// with a free-running cycle counter and queued in a small FIFO for a valid/ready reader.
module cnt_out_change_fifo #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               din,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [7:0]               rd_value,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               overflow_cnt
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] prev;
  logic [TS_W-1:0]   ts;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic [7:0]        ovf;
  logic [DATA_W-1:0] mem_value [DEPTH];
  logic [TS_W-1:0]   mem_ts    [DEPTH];

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A full FIFO still accepts an event when the head is popped on the same edge.
  always_comb begin
    change = (din != prev);
    full   = (occ == CNT_W'(DEPTH));
    pop    = rd_valid && rd_ready;
    push   = change && (!full || pop);
    drop   = change && full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      ovf    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_value[i] <= '0;
        mem_ts[i]    <= '0;
      end
    end else begin
      prev <= din;
      ts   <= ts + TS_W'(1);
      if (push) begin
        mem_value[wr_ptr] <= din;
        mem_ts[wr_ptr]    <= ts;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        occ <= occ + CNT_W'(1);
      else if (pop && !push)
        occ <= occ - CNT_W'(1);
      if (drop)
        ovf <= sat_inc(ovf);
    end
  end

  // Head is read straight from storage; no fall-through path from din.
  always_comb begin
    rd_valid     = (occ != '0);
    rd_value     = mem_value[rd_ptr];
    rd_ts        = mem_ts[rd_ptr];
    count        = occ;
    overflow_cnt = ovf;
  end

endmodule

// File: tb/tb_cnt_out_change_fifo.sv
// Directed bench for cnt_out_change_fifo: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_cnt_out_change_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_value;
  logic [7:0] rd_ts;
  logic [2:0] count;
  logic [7:0] overflow_cnt;

  int checks;
  int errors;

  cnt_out_change_fifo #(.DEPTH(4), .TS_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_value(rd_value),
    .rd_ts(rd_ts),
    .count(count),
    .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // Leaves the bench at a falling edge with reset released; next rising edge has ts=0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    din = 8'd0;
    rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_valid, rd_value, rd_ts, count, overflow_cnt} !== {1'b0, 8'd0, 8'd0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state got v=%0b val=%0d ts=%0d cnt=%0d ovf=%0d want all 0",
               rd_valid, rd_value, rd_ts, count, overflow_cnt);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({rd_valid, count, overflow_cnt} !== {1'b0, 3'd0, 8'd0}) begin
        errors++;
        $display("FAIL idle cycle %0d got v=%0b cnt=%0d ovf=%0d want 0 0 0",
                 i, rd_valid, count, overflow_cnt);
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_single_event();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    din = 8'd4;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({rd_valid, rd_value, rd_ts, count} !== {1'b1, 8'd4, 8'd5, 3'd1}) begin
        errors++;
        $display("FAIL single_hold cycle %0d got v=%0b val=%0d ts=%0d cnt=%0d want 1 4 5 1",
                 i, rd_valid, rd_value, rd_ts, count);
      end
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL single_pop got v=%0b cnt=%0d want 0 0", rd_valid, count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      din = 8'(i);
      step();
    end
    checks++;
    if ({count, overflow_cnt} !== {3'd4, 8'd1}) begin
      errors++;
      $display("FAIL overflow_fill got cnt=%0d ovf=%0d want 4 1", count, overflow_cnt);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_value, rd_ts} !== {1'b1, 8'(i + 1), 8'(i)}) begin
        errors++;
        $display("FAIL overflow_drain %0d got v=%0b val=%0d ts=%0d want 1 %0d %0d",
                 i, rd_valid, rd_value, rd_ts, i + 1, i);
      end
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, count, overflow_cnt} !== {1'b0, 3'd0, 8'd1}) begin
      errors++;
      $display("FAIL overflow_empty got v=%0b cnt=%0d ovf=%0d want 0 0 1",
               rd_valid, count, overflow_cnt);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_val [4];
    logic [7:0] exp_ts  [4];
    exp_val = '{8'd2, 8'd3, 8'd4, 8'd9};
    exp_ts  = '{8'd1, 8'd2, 8'd3, 8'd4};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      din = 8'(i);
      step();
    end
    din = 8'd9;
    rd_ready = 1'b1;
    step();
    checks++;
    if ({count, overflow_cnt} !== {3'd4, 8'd0}) begin
      errors++;
      $display("FAIL full_pop got cnt=%0d ovf=%0d want 4 0", count, overflow_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_value, rd_ts} !== {1'b1, exp_val[i], exp_ts[i]}) begin
        errors++;
        $display("FAIL full_pop_drain %0d got v=%0b val=%0d ts=%0d want 1 %0d %0d",
                 i, rd_valid, rd_value, rd_ts, exp_val[i], exp_ts[i]);
      end
      step();
    end
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL full_pop_empty got v=%0b cnt=%0d want 0 0", rd_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      din = 8'(i * 3);
      step();
      checks++;
      if ({rd_valid, rd_value, rd_ts, count} !== {1'b1, 8'(i * 3), 8'(i - 1), 3'd1}) begin
        errors++;
        $display("FAIL back_to_back %0d got v=%0b val=%0d ts=%0d cnt=%0d want 1 %0d %0d 1",
                 i, rd_valid, rd_value, rd_ts, count, i * 3, i - 1);
      end
    end
    step();
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, count, overflow_cnt} !== {1'b0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL back_to_back_end got v=%0b cnt=%0d ovf=%0d want 0 0 0",
               rd_valid, count, overflow_cnt);
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) step();
    din = 8'd1;
    step();
    din = 8'd2;
    step();
    checks++;
    if ({count, rd_value, rd_ts} !== {3'd2, 8'd1, 8'd255}) begin
      errors++;
      $display("FAIL ts_wrap_first got cnt=%0d val=%0d ts=%0d want 2 1 255", count, rd_value, rd_ts);
    end
    rd_ready = 1'b1;
    step();
    checks++;
    if ({rd_valid, rd_value, rd_ts} !== {1'b1, 8'd2, 8'd0}) begin
      errors++;
      $display("FAIL ts_wrap_second got v=%0b val=%0d ts=%0d want 1 2 0", rd_valid, rd_value, rd_ts);
    end
    step();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      din = 8'(i);
      step();
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++;
    if ({rd_valid, count, overflow_cnt} !== {1'b1, 3'd3, 8'd2}) begin
      errors++;
      $display("FAIL reset_mid_setup got v=%0b cnt=%0d ovf=%0d want 1 3 2",
               rd_valid, count, overflow_cnt);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({rd_valid, rd_value, rd_ts, count, overflow_cnt} !== {1'b0, 8'd0, 8'd0, 3'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_async got v=%0b val=%0d ts=%0d cnt=%0d ovf=%0d want all 0",
               rd_valid, rd_value, rd_ts, count, overflow_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    din = 8'd7;
    step();
    checks++;
    if ({rd_valid, rd_value, rd_ts, count, overflow_cnt} !== {1'b1, 8'd7, 8'd0, 3'd1, 8'd0}) begin
      errors++;
      $display("FAIL reset_release got v=%0b val=%0d ts=%0d cnt=%0d ovf=%0d want 1 7 0 1 0",
               rd_valid, rd_value, rd_ts, count, overflow_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    din = 8'd0;
    rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_event();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_ts_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_out_change_fifo.md
# cnt_out_change_fifo

Downstream consumer of the 8-bit counter-derived output bus of the cycle-count/transform stage. It watches that bus every clock, detects value changes, and time-stamps each change with a free-running cycle counter. Each change is buffered in a small FIFO and presented to a valid/ready reader. A saturating counter records events dropped on overflow, which makes the block the observation point for concolic coverage of the upstream stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- TS_W, 8, timestamp width in bits
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- din  input  8  upstream output bus, sampled every rising edge
- rd_ready  input  1  reader accepts head entry this cycle
- rd_valid  output  1  FIFO non-empty; head entry valid
- rd_value  output  8  din value recorded at head entry's change event
- rd_ts  output  TS_W  timestamp of head entry
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_cnt  output  8  dropped-event counter, saturating at 255

## Operation
- Reset values: rd_valid=0, rd_value=0, rd_ts=0, count=0, overflow_cnt=0.
  - Internal prev register=0, ts counter=0, write/read pointers=0.
  - All storage entries cleared to 0.
- ts counter:
  - Increments by 1 every clock when not in reset.
  - Wraps modulo 2^TS_W (max → 0); no flag on wrap.
- Change event: at an edge where din != prev.
  - prev loads din on every edge.
  - First comparison after reset is against 0, so a nonzero din at the first edge is an event.
- Push on an event: writes {din, ts} at the write pointer.
  - ts is the counter value before that edge increments it.
- Pop: at an edge where rd_valid && rd_ready; advances the read pointer.
- Pointers are log2(DEPTH) bits and wrap naturally. count tracks occupancy explicitly.
- Event on a full FIFO:
  - With pop in the same cycle: push accepted, count stays DEPTH, overflow_cnt unchanged.
  - Without pop: event dropped, FIFO unchanged, overflow_cnt += 1 unless already 255.
- Event and pop on a non-full, non-empty FIFO: both happen; count unchanged.
- Pop with count=0 is impossible, because rd_valid=0.
- rd_ready while rd_valid=0 is ignored.
- rd_value/rd_ts:
  - Driven directly from the head storage entry. No fall-through: a push into an empty FIFO becomes visible only after the edge.
  - When empty, they show the stale head entry (0 after reset). Readers must qualify them with rd_valid.
- Head stability: while rd_valid && !rd_ready, rd_value and rd_ts hold unchanged, regardless of pushes or drops.
- Reset asserted mid-operation:
  - All outputs go to reset values asynchronously, without waiting for an edge.
  - Stored entries and the overflow count are lost.
  - After reset deasserts, the first edge compares din against 0.

## Timing
- Event at edge N (din sampled at edge N differs from prev):
  - rd_valid=1 after edge N if the FIFO was empty.
  - count increments after edge N.
- Pop at edge M:
  - count decrements after edge M.
  - The next entry appears on rd_value/rd_ts after edge M. If none remains, rd_valid=0 after edge M.
- Latency, change to visible: 1 edge.
- Throughput: one push and one pop per cycle, sustained.
- overflow_cnt updates at the edge of the dropped event.
- din must be stable at the rising edge. The upstream stage updates its output after the edge, so a value change produced in cycle k is sampled at edge k+1.

## Test plan
- Idle after reset:
  - Stimulus: reset pulse, then din=0 for 10 cycles with rd_ready=1.
  - Required: rd_valid=0, count=0, overflow_cnt=0 throughout.
- Single event, reader stalled:
  - Stimulus: rd_ready=0; din 0→4 sampled at the edge where ts=5, then held.
  - Required: rd_valid=1, rd_value=4, rd_ts=5, count=1, all held for 5 cycles.
  - Then rd_ready=1 for one cycle → rd_valid=0, count=0.
- Overflow:
  - Stimulus: DEPTH=4, rd_ready=0; din sequence 1,2,3,4,5 on consecutive edges.
  - Required: count=4, overflow_cnt=1.
  - Draining yields values 1,2,3,4 with consecutive timestamps.
- Full with simultaneous pop:
  - Stimulus: fill to 4, then a change to 9 on the same edge as rd_ready=1.
  - Required: count stays 4, overflow_cnt unchanged, value 9 is the last entry drained.
- Timestamp wrap:
  - Stimulus: events at the edges where ts=255 and ts=0 (next edge).
  - Required: rd_ts reads 255 then 0, in order.
- Reset mid-operation:
  - Stimulus: count=3, overflow_cnt=2; assert reset between edges.
  - Required: all outputs 0 before the next edge.
  - After release, din=7 at the first edge → one entry {7, 0}.
